// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles into bytes and emits
// frames on an 8-bit AXI4-Stream through a small FWFT FIFO with frame counters.
module mii_rx_framer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int PREAMBLE_MIN = 2
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        mii_ce,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    input  logic [3:0]  mii_rxd,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_err,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state_reg;
    logic [3:0]  pre_cnt_reg;
    logic        armed_reg;
    logic        nib_odd_reg;
    logic [3:0]  low_nib_reg;
    logic        err_latch_reg;
    logic        pend_valid_reg;
    logic [7:0]  pend_data_reg;

    logic [9:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] free_cnt;
    logic [9:0]    rd_word;
    logic          pop;

    logic [15:0] frames_ok_reg;
    logic [15:0] frames_err_reg;
    logic        overflow_reg;

    logic        push_en;
    logic        push_last;
    logic        push_user;
    logic        inc_ok;
    logic        inc_err;
    logic        frame_abort;
    logic [7:0]  rx_byte;

    assign free_cnt = DEPTH_C - count_reg;
    assign rx_byte  = {mii_rxd, low_nib_reg};
    assign pop      = m_axis_tvalid && m_axis_tready;

    // Push/count decisions for the current nibble; the FSM and FIFO consume them.
    always_comb begin
        push_en     = 1'b0;
        push_last   = 1'b0;
        push_user   = 1'b0;
        inc_ok      = 1'b0;
        inc_err     = 1'b0;
        frame_abort = 1'b0;
        if (mii_ce && state_reg == DATA) begin
            if (!mii_rx_dv) begin
                if (pend_valid_reg) begin
                    push_en   = 1'b1;
                    push_last = 1'b1;
                    push_user = err_latch_reg | nib_odd_reg;
                    inc_ok    = ~push_user;
                    inc_err   = push_user;
                end else begin
                    inc_err = 1'b1;
                end
            end else if (nib_odd_reg && pend_valid_reg) begin
                if (free_cnt >= CW'(2)) begin
                    push_en = 1'b1;
                end else begin
                    // Last slot (if any) carries an errored terminator for the truncated frame.
                    frame_abort = 1'b1;
                    inc_err     = 1'b1;
                    if (free_cnt == CW'(1)) begin
                        push_en   = 1'b1;
                        push_last = 1'b1;
                        push_user = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg      <= IDLE;
            pre_cnt_reg    <= 4'd0;
            armed_reg      <= 1'b0;
            nib_odd_reg    <= 1'b0;
            low_nib_reg    <= 4'd0;
            err_latch_reg  <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= 8'd0;
        end else if (mii_ce) begin
            if (!mii_rx_dv) begin
                armed_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    // A frame in flight at reset release is dropped until the line goes idle.
                    if (mii_rx_dv) begin
                        if (armed_reg && mii_rxd == 4'h5) begin
                            state_reg   <= PREAMBLE;
                            pre_cnt_reg <= 4'd1;
                        end else begin
                            state_reg <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!mii_rx_dv) begin
                        state_reg <= IDLE;
                    end else if (mii_rxd == 4'h5) begin
                        if (pre_cnt_reg != 4'hF) begin
                            pre_cnt_reg <= pre_cnt_reg + 4'd1;
                        end
                    end else if (mii_rxd == 4'hD && int'(pre_cnt_reg) >= PREAMBLE_MIN) begin
                        state_reg      <= DATA;
                        nib_odd_reg    <= 1'b0;
                        err_latch_reg  <= 1'b0;
                        pend_valid_reg <= 1'b0;
                    end else begin
                        state_reg <= DROP;
                    end
                end
                DATA: begin
                    if (!mii_rx_dv) begin
                        state_reg      <= IDLE;
                        pend_valid_reg <= 1'b0;
                    end else begin
                        if (mii_rx_er) begin
                            err_latch_reg <= 1'b1;
                        end
                        if (!nib_odd_reg) begin
                            low_nib_reg <= mii_rxd;
                            nib_odd_reg <= 1'b1;
                        end else begin
                            nib_odd_reg <= 1'b0;
                            if (frame_abort) begin
                                state_reg      <= DROP;
                                pend_valid_reg <= 1'b0;
                            end else begin
                                pend_valid_reg <= 1'b1;
                                pend_data_reg  <= rx_byte;
                            end
                        end
                    end
                end
                DROP: begin
                    if (!mii_rx_dv) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_en) begin
            fifo_mem[wr_ptr_reg] <= {push_user, push_last, pend_data_reg};
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push_en) - CW'(pop);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            frames_ok_reg  <= 16'd0;
            frames_err_reg <= 16'd0;
            overflow_reg   <= 1'b0;
        end else begin
            if (inc_ok && frames_ok_reg != 16'hFFFF) begin
                frames_ok_reg <= frames_ok_reg + 16'd1;
            end
            if (inc_err && frames_err_reg != 16'hFFFF) begin
                frames_err_reg <= frames_err_reg + 16'd1;
            end
            if (frame_abort) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // First-word-fall-through view; payload forced to zero while empty.
    assign rd_word       = fifo_mem[rd_ptr_reg];
    assign m_axis_tvalid = (count_reg != '0);
    assign m_axis_tdata  = m_axis_tvalid ? rd_word[7:0] : 8'd0;
    assign m_axis_tlast  = m_axis_tvalid & rd_word[8];
    assign m_axis_tuser  = m_axis_tvalid & rd_word[9];
    assign frames_ok     = frames_ok_reg;
    assign frames_err    = frames_err_reg;
    assign overflow      = overflow_reg;

endmodule
